acl_display_fmt: RTL and testbench

Parametrised formatter between accelerometer sample registers and the `seven_seg` scanner. Captures NCH signed-magnitude channel values on a strobe and converts each to DIGITS decimal (or hex) digits with a serial double-dabble engine. It then commits all channels atomically to a display register and answers the scanner's per-anode `can` poll with `val`/`d`/`valid`. It replaces the fixed 3×2-digit combinational mapping in `top` and adds hex mode, leading-zero blanking, overflow saturation, a hold mode and drop counting.

---
 rtl/acl_display_fmt.sv | 162 ++++++++++++++++
 tb/tb_acl_display_fmt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_display_fmt.sv
// Accelerometer display formatter: latches signed-magnitude channels, converts them serially
// to decimal (double-dabble) or hex digits, and commits the full set atomically for the scanner.
module acl_display_fmt #(
    parameter int NCH    = 3,
    parameter int W      = 4,
    parameter int DIGITS = 2
) (
    input  logic                   clk_100mhz,
    input  logic                   rst,
    input  logic [NCH*(W+1)-1:0]   samples,
    input  logic                   sample_valid,
    input  logic                   hold,
    input  logic                   mode_hex,
    input  logic                   blank_lz,
    input  logic [2:0]             can,
    output logic [3:0]             val,
    output logic                   d,
    output logic                   valid,
    output logic                   busy,
    output logic [NCH-1:0]         ovf,
    output logic [7:0]             drop_cnt
);
    localparam int BW     = 4*DIGITS + 4;
    localparam int HW     = 4*DIGITS;
    localparam int MW     = (W > HW) ? W : HW;
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BITW   = (W > 1) ? $clog2(W) : 1;
    localparam int STRIDE = DIGITS + 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t state;

    logic [W-1:0]    lat_mag [NCH];
    logic [NCH-1:0]  lat_sign;
    logic            lat_hex;
    logic [CHW-1:0]  ch;
    logic [BITW-1:0] bit_idx;
    logic [BW-1:0]   bcd;

    logic [3:0]      sh_dig [NCH][DIGITS];
    logic [NCH-1:0]  sh_neg;
    logic [NCH-1:0]  sh_ovf;
    logic [3:0]      disp_dig [NCH][DIGITS];
    logic [NCH-1:0]  disp_neg;

    logic [W-1:0]    cur_mag;
    logic            feed;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   bcd_next;
    logic [MW-1:0]   ext;
    logic [3:0]      res_dig [DIGITS];
    logic            res_ovf;
    logic            res_neg;
    logic            lit;

    // One conversion step plus the per-channel result it would store on the last step.
    always_comb begin
        cur_mag = lat_mag[ch];
        feed    = cur_mag[BITW'(W-1) - bit_idx];
        adj     = bcd;
        for (int i = 0; i <= DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        bcd_next = BW'({adj, feed});
        ext      = MW'(cur_mag);
        res_ovf  = lat_hex ? (|(ext >> HW)) : (bcd_next[BW-1 -: 4] != 4'd0);
        res_neg  = lat_sign[ch] & (cur_mag != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (res_ovf) res_dig[k] = lat_hex ? 4'hF : 4'd9;
            else         res_dig[k] = lat_hex ? ext[4*k +: 4] : bcd_next[4*k +: 4];
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ch       <= '0;
            bit_idx  <= '0;
            bcd      <= '0;
            lat_hex  <= 1'b0;
            lat_sign <= '0;
            drop_cnt <= 8'd0;
            sh_neg   <= '0;
            sh_ovf   <= '0;
            disp_neg <= '0;
            ovf      <= '0;
            for (int c = 0; c < NCH; c++) begin
                lat_mag[c] <= '0;
                for (int k = 0; k < DIGITS; k++) begin
                    sh_dig[c][k]   <= 4'd0;
                    disp_dig[c][k] <= 4'd0;
                end
            end
        end else begin
            // COMMIT counts as busy, so a strobe landing there is a drop.
            if (sample_valid && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (sample_valid && !hold) begin
                        for (int c = 0; c < NCH; c++) begin
                            lat_mag[c]  <= samples[c*(W+1) +: W];
                            lat_sign[c] <= samples[c*(W+1) + W];
                        end
                        lat_hex <= mode_hex;
                        ch      <= '0;
                        bit_idx <= '0;
                        bcd     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd     <= bcd_next;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == BITW'(W-1)) begin
                        for (int k = 0; k < DIGITS; k++) sh_dig[ch][k] <= res_dig[k];
                        sh_neg[ch] <= res_neg;
                        sh_ovf[ch] <= res_ovf;
                        bcd        <= '0;
                        bit_idx    <= '0;
                        ch         <= ch + 1'b1;
                        if (ch == CHW'(NCH-1)) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int c = 0; c < NCH; c++) begin
                        for (int k = 0; k < DIGITS; k++) disp_dig[c][k] <= sh_dig[c][k];
                    end
                    disp_neg <= sh_neg;
                    ovf      <= sh_ovf;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Anode decode; positions at k == DIGITS are separators between channels.
    always_comb begin
        val   = 4'd0;
        d     = 1'b0;
        valid = 1'b0;
        lit   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (can == 3'(c*STRIDE + k)) begin
                    lit = !blank_lz || (k == 0);
                    for (int j = k; j < DIGITS; j++) begin
                        if (disp_dig[c][j] != 4'd0) lit = 1'b1;
                    end
                    if (lit) begin
                        val   = disp_dig[c][k];
                        valid = 1'b1;
                        d     = (k == 0) && disp_neg[c];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_acl_display_fmt.sv
// Bench for acl_display_fmt: driver issues captures and queues the expected display set,
// a monitor checks every committed set across all anodes.
module tb_acl_display_fmt;
  localparam int NCH    = 3;
  localparam int W      = 4;
  localparam int DIGITS = 2;
  localparam int SW     = NCH*(W+1);
  localparam int CS     = 4*DIGITS + 2;
  localparam int EW     = NCH*CS;
  localparam int STRIDE = DIGITS + 1;

  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  logic [SW-1:0] samples = '0;
  logic sample_valid = 1'b0, hold = 1'b0, mode_hex = 1'b0, blank_lz = 1'b0;
  logic [2:0] can = 3'd0;
  logic [3:0] val;
  logic d, valid, busy;
  logic [NCH-1:0] ovf;
  logic [7:0] drop_cnt;

  logic [17:0] samples2 = '0;
  logic sample_valid2 = 1'b0;
  logic [2:0] can2 = 3'd0;
  logic [3:0] val2;
  logic d2, valid2, busy2;
  logic [1:0] ovf2;
  logic [7:0] drop_cnt2;

  int checks = 0;
  int failures = 0;
  int exp_drop = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_rec, zero_rec;

  acl_display_fmt #(.NCH(NCH), .W(W), .DIGITS(DIGITS)) u_dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .samples(samples), .sample_valid(sample_valid),
    .hold(hold), .mode_hex(mode_hex), .blank_lz(blank_lz), .can(can), .val(val), .d(d),
    .valid(valid), .busy(busy), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  acl_display_fmt #(.NCH(2), .W(8), .DIGITS(2)) u_dut2 (
    .clk_100mhz(clk_100mhz), .rst(rst), .samples(samples2), .sample_valid(sample_valid2),
    .hold(1'b0), .mode_hex(1'b0), .blank_lz(1'b0), .can(can2), .val(val2), .d(d2),
    .valid(valid2), .busy(busy2), .ovf(ovf2), .drop_cnt(drop_cnt2)
  );

  // clock / reset
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: digits by division, overflow when the magnitude exceeds what DIGITS can show.
  function automatic logic [EW-1:0] model(input logic [SW-1:0] s, input logic hex);
    logic [EW-1:0] r;
    int mag, base, lim, p;
    logic o;
    r = '0;
    base = hex ? 16 : 10;
    lim = 1;
    for (int k = 0; k < DIGITS; k++) lim = lim * base;
    for (int c = 0; c < NCH; c++) begin
      mag = int'(s[c*(W+1) +: W]);
      o = (mag >= lim);
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
        r[c*CS + 4*k +: 4] = o ? 4'(base - 1) : 4'((mag / p) % base);
        p = p * base;
      end
      r[c*CS + 4*DIGITS]     = s[c*(W+1) + W] && (mag != 0);
      r[c*CS + 4*DIGITS + 1] = o;
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] rec_ovf(input logic [EW-1:0] rec);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = rec[c*CS + 4*DIGITS + 1];
    return r;
  endfunction

  function automatic logic [5:0] exp_decode(input logic [EW-1:0] rec, input int cn, input logic bl);
    int c, k;
    logic lit;
    c = cn / STRIDE;
    k = cn % STRIDE;
    if (k == DIGITS || c >= NCH) return 6'd0;
    lit = !bl || (k == 0);
    for (int j = k; j < DIGITS; j++) if (rec[c*CS + 4*j +: 4] != 4'd0) lit = 1'b1;
    if (!lit) return 6'd0;
    return {1'b1, (k == 0) && rec[c*CS + 4*DIGITS], rec[c*CS + 4*k +: 4]};
  endfunction

  task automatic check_display(input logic [EW-1:0] rec, input string tag);
    check({tag, " ovf"}, 32'(ovf), 32'(rec_ovf(rec)));
    for (int b = 0; b < 2; b++) begin
      for (int cn = 0; cn < 8; cn++) begin
        blank_lz = b[0];
        can = 3'(cn);
        #1;
        check($sformatf("%s can%0d blz%0d {valid,d,val}", tag, cn, b), 32'({valid, d, val}),
              32'(exp_decode(rec, cn, b[0])));
      end
    end
    blank_lz = 1'b0;
  endtask

  // driver
  task automatic convert(input logic [SW-1:0] s, input logic hex, input int drop_at, input int hold_at);
    logic [EW-1:0] rec;
    int n;
    rec = model(s, hex);
    exp_q.push_back(rec);
    @(negedge clk_100mhz);
    samples = s;
    mode_hex = hex;
    sample_valid = 1'b1;
    @(negedge clk_100mhz);
    sample_valid = 1'b0;
    samples = SW'($urandom());
    mode_hex = 1'($urandom_range(0, 1));
    n = 0;
    while (busy && n < 200) begin
      n++;
      sample_valid = (n == drop_at);
      if (n == hold_at) hold = 1'b1;
      @(negedge clk_100mhz);
    end
    sample_valid = 1'b0;
    hold = 1'b0;
    if (drop_at > 0) exp_drop++;
    check("busy cycles", 32'(n), 32'(NCH*W + 1));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    repeat (20) @(negedge clk_100mhz);
    last_rec = rec;
  endtask

  // monitor: every busy falling edge presents a committed set
  initial begin : monitor
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (prev_busy && !busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL commit_without_expect actual=commit required=none");
        end else begin
          check_display(exp_q.pop_front(), "commit");
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : stimulus
    int n;
    zero_rec = model('0, 1'b0);
    last_rec = zero_rec;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    check_display(zero_rec, "reset");

    convert({5'b01101, 5'b10111, 5'b00000}, 1'b0, -1, -1);
    convert({5'b00101, 5'b11111, 5'b00001}, 1'b0, 5, -1);

    hold = 1'b1;
    @(negedge clk_100mhz);
    samples = {5'b01111, 5'b01111, 5'b01111};
    sample_valid = 1'b1;
    @(negedge clk_100mhz);
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold busy", 32'(busy), 32'd0);
      @(negedge clk_100mhz);
    end
    check("hold drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check_display(last_rec, "hold");
    hold = 1'b0;

    convert({5'b01101, 5'b00000, 5'b10011}, 1'b1, -1, -1);
    convert({5'b11010, 5'b00110, 5'b11001}, 1'b0, -1, 4);
    convert({5'b00111, 5'b11100, 5'b01000}, 1'b0, NCH*W + 1, -1);

    @(negedge clk_100mhz);
    samples = {5'b01001, 5'b01001, 5'b01001};
    sample_valid = 1'b1;
    @(negedge clk_100mhz);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    exp_q.delete();
    exp_q.push_back(zero_rec);
    rst = 1'b1;
    @(negedge clk_100mhz);
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid drop_cnt", 32'(drop_cnt), 32'd0);
    exp_drop = 0;
    repeat (20) @(negedge clk_100mhz);
    rst = 1'b0;
    last_rec = zero_rec;

    for (int i = 0; i < 10; i++) begin
      convert(SW'($urandom()), 1'($urandom_range(0, 1)), -1, -1);
    end

    @(negedge clk_100mhz);
    samples2 = {1'b0, 8'd99, 1'b0, 8'd200};
    sample_valid2 = 1'b1;
    @(negedge clk_100mhz);
    sample_valid2 = 1'b0;
    n = 0;
    while (busy2 && n < 200) begin
      n++;
      @(negedge clk_100mhz);
    end
    check("wide busy cycles", 32'(n), 32'd17);
    check("wide ovf", 32'(ovf2), 32'b01);
    for (int cn = 0; cn < 5; cn++) begin
      can2 = 3'(cn);
      #1;
      check($sformatf("wide can%0d {valid,d,val}", cn), 32'({valid2, d2, val2}),
            (cn == 2) ? 32'd0 : 32'h29);
    end

    check("expect queue drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
